// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache for the
// MEM stage. Hits complete combinationally in COMPARE. A miss writes back a
// dirty victim, then refills the line over a line-wide request/response port.
// The CPU retries the access, and that retry hits.
//
// Optional feature: define DATA_CACHE_STATS_EN to enable the hit_count and
// miss_count counters. When it is undefined, both outputs are tied to zero.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   is_input_valid      CPU access this cycle (addr, din, mem_read, mem_write)
//   is_ready            cache in COMPARE and able to accept a request
//   is_output_valid     is_hit/dout meaningful this cycle
//   is_hit, dout        hit flag and load data (dout is 0 unless read hit)
//   mem_req_*           line request to backing memory (valid/ready handshake)
//   mem_resp_*          refill line (one-cycle pulse)
//   hit_count/miss_count statistics counters
module data_cache #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_SETS   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       is_input_valid,
  input  logic [31:0]                addr,
  input  logic [31:0]                din,
  input  logic                       mem_read,
  input  logic                       mem_write,
  output logic                       is_ready,
  output logic                       is_output_valid,
  output logic                       is_hit,
  output logic [31:0]                dout,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_write,
  output logic [31:0]                mem_req_addr,
  output logic [32*LINE_WORDS-1:0]   mem_req_data,
  input  logic                       mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0]   mem_resp_data,
  output logic [31:0]                hit_count,
  output logic [31:0]                miss_count
);

  localparam int unsigned OB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(NUM_SETS);
  localparam int unsigned TW = 30 - OB - IB;
  localparam int unsigned LW = 32 * LINE_WORDS;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TW-1:0]       tag_arr  [NUM_SETS];
  logic [LW-1:0]       data_arr [NUM_SETS];
  logic [TW-1:0]       miss_tag;
  logic [IB-1:0]       miss_index;

  logic [OB-1:0] word;
  logic [IB-1:0] index;
  logic [TW-1:0] tag;
  logic          unused_addr_bits;
  logic          in_compare;
  logic          hit_raw;
  logic          hit;
  logic          miss;
  logic          is_write;
  logic          is_read;

  assign word             = addr[OB+1:2];
  assign index            = addr[OB+IB+1:OB+2];
  assign tag              = addr[31:OB+IB+2];
  assign unused_addr_bits = ^addr[1:0];

  assign in_compare = (state == COMPARE);
  assign hit_raw    = valid_q[index] && (tag_arr[index] == tag);
  assign hit        = in_compare && is_input_valid && hit_raw;
  assign miss       = in_compare && is_input_valid && !hit_raw;
  // A simultaneous read and write request is handled as a store.
  assign is_write   = mem_write;
  assign is_read    = mem_read && !mem_write;

  assign is_ready        = in_compare;
  assign is_output_valid = in_compare && is_input_valid;
  assign is_hit          = hit;

  always_comb begin
    dout = '0;
    if (hit && is_read) dout = data_arr[index][{word, 5'd0} +: 32];
  end

  // The request fields come only from latched miss state and from storage
  // that is not written until the refill. They therefore stay stable while
  // the memory is not ready.
  assign mem_req_valid = (state == WRITEBACK) || (state == ALLOC_REQ);
  assign mem_req_write = (state == WRITEBACK);
  assign mem_req_data  = data_arr[miss_index];
  always_comb begin
    if (state == WRITEBACK) mem_req_addr = {tag_arr[miss_index], miss_index, {(OB+2){1'b0}}};
    else                    mem_req_addr = {miss_tag, miss_index, {(OB+2){1'b0}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COMPARE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      case (state)
        COMPARE: begin
          if (hit && is_write) dirty_q[index] <= 1'b1;
          if (miss) begin
            miss_tag   <= tag;
            miss_index <= index;
            state      <= (valid_q[index] && dirty_q[index]) ? WRITEBACK : ALLOC_REQ;
          end
        end
        WRITEBACK: begin
          if (mem_req_ready) begin
            dirty_q[miss_index] <= 1'b0;
            state               <= ALLOC_REQ;
          end
        end
        ALLOC_REQ: begin
          if (mem_req_ready) state <= ALLOC_WAIT;
        end
        ALLOC_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[miss_index] <= 1'b1;
            dirty_q[miss_index] <= 1'b0;
            state               <= COMPARE;
          end
        end
        default: state <= COMPARE;
      endcase
    end
  end

  // Tags and line data have no reset. The valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (hit && is_write) data_arr[index][{word, 5'd0} +: 32] <= din;
    if ((state == ALLOC_WAIT) && mem_resp_valid) begin
      data_arr[miss_index] <= mem_resp_data;
      tag_arr[miss_index]  <= miss_tag;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic [31:0]  din;
  logic         mem_read;
  logic         mem_write;
  logic         is_ready;
  logic         is_output_valid;
  logic         is_hit;
  logic [31:0]  dout;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  always #5 clk = ~clk;

  data_cache #(.LINE_WORDS(4), .NUM_SETS(16)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .din(din), .mem_read(mem_read), .mem_write(mem_write), .is_ready(is_ready),
    .is_output_valid(is_output_valid), .is_hit(is_hit), .dout(dout),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic         chk_data;
    logic [127:0] data;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned ready_delay = 0;
  int unsigned wb_stall = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // Backing memory line contents: each word holds 0xA0000000 | its byte address.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = 32'hA000_0000 | a | (i << 2);
    return l;
  endfunction

  // Backing memory: ready after ready_delay+1 cycles of request; response 2 cycles after a read handshake.
  initial begin
    logic        hs, v, w;
    logic [31:0] a, resp_addr;
    int unsigned wait_cnt, resp_cnt;
    wait_cnt = 0; resp_cnt = 0; resp_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready && !reset;
      v  = mem_req_valid && !reset;
      w  = mem_req_write;
      a  = mem_req_addr;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (reset) begin
        wait_cnt = 0; resp_cnt = 0; mem_req_ready = 1'b0;
      end else begin
        if (resp_cnt != 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = line_of(resp_addr);
          end
        end
        if (hs) begin
          mem_req_ready = 1'b0;
          wait_cnt = 0;
          if (!w) begin resp_cnt = 2; resp_addr = a; end
        end else if (v) begin
          if (wait_cnt >= ready_delay) mem_req_ready = 1'b1;
          else wait_cnt++;
        end
      end
    end
  end

  // Response monitor: pops one expectation per presented CPU output.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset && is_output_valid) begin
        if (resp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          e = resp_q.pop_front();
          chk("resp_hit_dout", {95'd0, is_hit, dout}, {95'd0, e.hit, e.data});
        end
      end
    end
  end

  // Request monitor: handshakes against expectations, stability while stalled.
  initial begin
    req_t        e;
    logic        pv, pr, pw;
    logic [31:0]  pa;
    logic [127:0] pd;
    pv = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset) pv = 1'b0;
      else begin
        if (mem_req_valid) begin
          if (is_ready !== 1'b0) fail_now("busy_but_ready");
          if (mem_req_write && !mem_req_ready) wb_stall++;
        end
        if (pv && !pr && mem_req_valid)
          chk("req_stable", {mem_req_write, mem_req_addr, mem_req_data}, {pw, pa, pd});
        if (mem_req_valid && mem_req_ready) begin
          if (req_q.size() == 0) fail_now("req_unexpected");
          else begin
            e = req_q.pop_front();
            chk("req_write", {127'd0, mem_req_write}, {127'd0, e.wr});
            chk("req_addr", {96'd0, mem_req_addr}, {96'd0, e.addr});
            if (e.chk_data) chk("req_data", mem_req_data, e.data);
          end
        end
        pv = mem_req_valid; pr = mem_req_ready; pw = mem_req_write;
        pa = mem_req_addr; pd = mem_req_data;
      end
    end
  end

  // Presents one access and holds it until it hits, as the stalled pipeline would.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    int unsigned n;
    n = 0;
    @(posedge clk); #1;
    is_input_valid = 1'b1; addr = a; mem_read = rd; mem_write = wr; din = d;
    forever begin
      @(negedge clk);
      if (is_output_valid && is_hit) break;
      n++;
      if (n > 200) begin fail_now("access_timeout"); break; end
    end
    @(posedge clk); #1;
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic push_resp(input logic h, input logic [31:0] d);
    resp_t r;
    r.hit = h; r.data = d;
    resp_q.push_back(r);
    if (h) exp_hits++;
    else   exp_miss++;
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic c, input logic [127:0] d);
    req_t r;
    r.wr = w; r.addr = a; r.chk_data = c; r.data = d;
    req_q.push_back(r);
  endtask

  task automatic check_stats(input string name);
`ifdef DATA_CACHE_STATS_EN
    chk({name, "_hits"}, {96'd0, hit_count}, {96'd0, exp_hits});
    chk({name, "_miss"}, {96'd0, miss_count}, {96'd0, exp_miss});
`else
    chk({name, "_hits"}, {96'd0, hit_count}, 128'd0);
    chk({name, "_miss"}, {96'd0, miss_count}, 128'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int unsigned n;
    reset = 1'b1; is_input_valid = 1'b0; addr = '0; din = '0;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rst_is_ready", {127'd0, is_ready}, 128'd1);
    chk("rst_req_valid", {127'd0, mem_req_valid}, 128'd0);
    chk("rst_out_valid", {127'd0, is_output_valid}, 128'd0);
    chk("rst_dout", {96'd0, dout}, 128'd0);
    check_stats("rst");

    // Cold miss, clean victim: read refill, then the retry hits.
    push_req(1'b0, 32'h100, 1'b0, '0);
    push_resp(1'b0, 32'h0);
    push_resp(1'b1, 32'hA000_0100);
    access(32'h100, 1'b1, 1'b0, 32'h0);

    // Store hit (dout 0), then a load of the stored word.
    push_resp(1'b1, 32'h0);
    access(32'h104, 1'b0, 1'b1, 32'hDEAD_BEEF);
    push_resp(1'b1, 32'hDEAD_BEEF);
    access(32'h104, 1'b1, 1'b0, 32'h0);

    // Conflict miss on a dirty line, with ready held low for 5 cycles.
    ready_delay = 4;
    wb_stall = 0;
    push_req(1'b1, 32'h100, 1'b1, 128'hA000010C_A0000108_DEADBEEF_A0000100);
    push_req(1'b0, 32'h500, 1'b0, '0);
    push_resp(1'b0, 32'h0);
    push_resp(1'b1, 32'hA000_0504);
    access(32'h504, 1'b1, 1'b0, 32'h0);
    chk("wb_stall_cycles", {96'd0, wb_stall}, 128'd5);
    check_stats("pre_reset");
    ready_delay = 0;

    // Miss to 0x208, then reset while waiting for the refill.
    push_req(1'b0, 32'h200, 1'b0, '0);
    push_resp(1'b0, 32'h0);
    @(posedge clk); #1;
    is_input_valid = 1'b1; addr = 32'h208; mem_read = 1'b1; mem_write = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_req_valid && mem_req_ready) && n < 50);
    chk("alloc_hs_seen", {127'd0, mem_req_valid && mem_req_ready}, 128'd1);
    @(posedge clk); #2;
    chk("alloc_wait_busy", {127'd0, is_ready}, 128'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_ready", {127'd0, is_ready}, 128'd1);
    chk("async_rst_req", {127'd0, mem_req_valid}, 128'd0);
    is_input_valid = 1'b0; mem_read = 1'b0;
    exp_hits = 0; exp_miss = 0;
    @(negedge clk); reset = 1'b0;

    // Valid bits are cleared, so 0x100 misses again.
    push_req(1'b0, 32'h100, 1'b0, '0);
    push_resp(1'b0, 32'h0);
    push_resp(1'b1, 32'hA000_0100);
    access(32'h100, 1'b1, 1'b0, 32'h0);

    // Read and write both set: the access acts as a store.
    push_resp(1'b1, 32'h0);
    access(32'h10C, 1'b1, 1'b1, 32'h1234_5678);
    push_resp(1'b1, 32'h1234_5678);
    access(32'h10C, 1'b1, 1'b0, 32'h0);

    // An idle input produces no output and dout stays 0.
    @(negedge clk);
    chk("idle_out_valid", {127'd0, is_output_valid}, 128'd0);
    chk("idle_dout", {96'd0, dout}, 128'd0);
    check_stats("final");
    chk("resp_q_drained", 128'(resp_q.size()), 128'd0);
    chk("req_q_drained", 128'(req_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
